// File: rtl/min_sec_carry.sv
// BCD mm:ss counter behind a 1 Hz prescaler. It pulses hour_carry on each 59:59 -> 00:00 rollover
// and accepts a validated time-set load.
module min_sec_carry #(
   parameter int CLK_DIV = 50000000,
   parameter int DIV_W   = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   output logic [3:0] sec_1,
   output logic [3:0] sec_2,
   output logic [3:0] min_1,
   output logic [3:0] min_2,
   output logic       tick_1hz,
   output logic       hour_carry,
   output logic       load_err
);

   logic [DIV_W-1:0] div_cnt;
   logic             tick_int;
   logic             load_ok;
   logic             load_take;

   assign tick_int  = run && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign load_ok   = (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                      (load_min[7:4] <= 4'd5) && (load_min[3:0] <= 4'd9);
   assign load_take = load && load_ok;

   // A valid load restarts the second and masks any coinciding tick; a rejected load is ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= '0;
         sec_1      <= 4'd0;
         sec_2      <= 4'd0;
         min_1      <= 4'd0;
         min_2      <= 4'd0;
         tick_1hz   <= 1'b0;
         hour_carry <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         tick_1hz   <= 1'b0;
         hour_carry <= 1'b0;
         load_err   <= load && !load_ok;
         if (load_take) begin
            div_cnt <= '0;
            sec_1   <= load_sec[3:0];
            sec_2   <= load_sec[7:4];
            min_1   <= load_min[3:0];
            min_2   <= load_min[7:4];
         end else if (tick_int) begin
            div_cnt  <= '0;
            tick_1hz <= 1'b1;
            if (sec_1 != 4'd9) begin
               sec_1 <= sec_1 + 4'd1;
            end else begin
               sec_1 <= 4'd0;
               if (sec_2 != 4'd5) begin
                  sec_2 <= sec_2 + 4'd1;
               end else begin
                  sec_2 <= 4'd0;
                  if (min_1 != 4'd9) begin
                     min_1 <= min_1 + 4'd1;
                  end else begin
                     min_1 <= 4'd0;
                     if (min_2 != 4'd5) begin
                        min_2 <= min_2 + 4'd1;
                     end else begin
                        min_2      <= 4'd0;
                        hour_carry <= 1'b1;
                     end
                  end
               end
            end
         end else if (run) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_min_sec_carry.sv
// Self-checking bench for min_sec_carry. A seconds-as-integer reference model pushes the expected
// outputs every clock, and a monitor pops and compares them just after the edge.
module tb_min_sec_carry;

   localparam int CLK_DIV = 4;
   localparam int DIV_W   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_min = 8'h00;
   logic [7:0] load_sec = 8'h00;
   logic [3:0] sec_1, sec_2, min_1, min_2;
   logic       tick_1hz, hour_carry, load_err;

   typedef struct packed {
      logic [15:0] digits;
      logic [2:0]  pulses;
   } exp_t;

   exp_t sb[$];
   int   m_phase = 0;
   int   m_secs  = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   carry_seen = 0;

   min_sec_carry #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .run(run), .load(load),
      .load_min(load_min), .load_sec(load_sec),
      .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
      .tick_1hz(tick_1hz), .hour_carry(hour_carry), .load_err(load_err)
   );

   always #5 clk = ~clk;

   function automatic bit bcd_ok(input logic [7:0] b);
      return (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
   endfunction

   function automatic int bcd_to_secs(input logic [7:0] m, input logic [7:0] s);
      return (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 + int'(s[7:4]) * 10 + int'(s[3:0]);
   endfunction

   function automatic logic [15:0] secs_to_bcd(input int t);
      int m, s;
      m = t / 60;
      s = t % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: computes the state the DUT should show after this edge
   always @(posedge clk) begin
      exp_t e;
      e.pulses = 3'b000;
      if (rst) begin
         m_phase = 0;
         m_secs  = 0;
      end else begin
         e.pulses[0] = load && !(bcd_ok(load_min) && bcd_ok(load_sec));
         if (load && bcd_ok(load_min) && bcd_ok(load_sec)) begin
            m_secs  = bcd_to_secs(load_min, load_sec);
            m_phase = 0;
         end else if (run) begin
            if (m_phase == CLK_DIV - 1) begin
               m_phase     = 0;
               e.pulses[2] = 1'b1;
               if (m_secs == 3599) begin
                  m_secs      = 0;
                  e.pulses[1] = 1'b1;
               end else begin
                  m_secs = m_secs + 1;
               end
            end else begin
               m_phase = m_phase + 1;
            end
         end
      end
      e.digits = secs_to_bcd(m_secs);
      sb.push_back(e);
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (hour_carry === 1'b1) carry_seen++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_output("digits", {min_2, min_1, sec_2, sec_1}, e.digits);
         check_output("tick/carry/err", {13'd0, tick_1hz, hour_carry, load_err}, {13'd0, e.pulses});
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_stimulus(input logic r, input logic rn, input logic ld,
                                 input logic [7:0] lm, input logic [7:0] ls, input int n);
      rst = r; run = rn; load = ld; load_min = lm; load_sec = ls;
      step(n);
   endtask

   task automatic wait_phase(input int p);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (m_phase == p) hit = 1'b1;
         else step(1);
      end
      if (!hit) check_output("wait_phase", 16'd0, 16'd1);
   endtask

   initial begin
      int c0;
      step(3);
      // Free run for ten ticks from reset
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 40);
      check_output("secs_after_10_ticks", {min_2, min_1, sec_2, sec_1}, 16'h0010);

      // Load 59:58 and count carries across 3602 ticks
      c0 = carry_seen;
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'h59, 8'h58, 1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4 * 3602);
      check_output("carries_in_window", 16'(carry_seen - c0), 16'd2);

      // Rejected loads leave counting untouched
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'h12, 8'h60, 1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5);
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'h0A, 8'h15, 1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 6);

      // Valid load landing on a tick edge
      wait_phase(CLK_DIV - 1);
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1);
      check_output("load_on_tick", {min_2, min_1, sec_2, sec_1}, 16'h1234);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 9);

      // Pause with the prescaler at 2
      wait_phase(2);
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 10);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8);

      // Reset beats a due rollover and a simultaneous load
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'h59, 8'h59, 1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1);
      wait_phase(CLK_DIV - 1);
      c0 = carry_seen;
      apply_stimulus(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1);
      check_output("rst_over_rollover", {min_2, min_1, sec_2, sec_1}, 16'h0000);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8);
      check_output("no_carry_after_rst", 16'(carry_seen - c0), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
